// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur runner obstacle datapath.
package dino_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } game_state_t;

   localparam int POS_W    = 10;
   localparam int SCREEN_W = 640;
   localparam int SPRITE_W = 60;
   localparam int EXIT_POS = SCREEN_W + SPRITE_W;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 expressed as register bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One cactus slot: holds a scroll position and active flag, advances by speed on each frame.
module obstacle_slot #(
   parameter int EXIT_POS = dino_pkg::EXIT_POS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_adv,
   input  logic       spawn,
   input  logic       clear,
   input  logic [3:0] speed,
   output logic [9:0] pos,
   output logic       active,
   output logic       retire_next
);

   logic [10:0] pos_sum;

   // 11-bit sum so the exit compare never sees a wrapped position
   assign pos_sum     = {1'b0, pos} + {7'd0, speed};
   assign retire_next = (pos_sum >= 11'(EXIT_POS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos    <= '0;
         active <= 1'b0;
      end else if (clear) begin
         pos    <= '0;
         active <= 1'b0;
      end else if (spawn) begin
         pos    <= '0;
         active <= 1'b1;
      end else if (tick_adv && active) begin
         if (retire_next) begin
            pos    <= '0;
            active <= 1'b0;
         end else begin
            pos <= pos_sum[9:0];
         end
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game sequencer: run/over state machine, speed ramp, score, spawn scheduling over NSLOT slots.
//   state | meaning
//   IDLE  | after reset, waiting for START, outputs held
//   RUN   | game in progress, frame ticks advance slots, score and speed
//   OVER  | collision seen, everything frozen until START
module obstacle_scheduler #(
   parameter int NSLOT       = 3,
   parameter int SPEED_INIT  = 4,
   parameter int SPEED_MAX   = 12,
   parameter int RAMP_FRAMES = 600,
   parameter int MIN_GAP     = 40,
   parameter int GAP_MASK    = 63,
   parameter int EXIT_POS    = dino_pkg::EXIT_POS
) (
   input  logic                clk,
   input  logic                RESET_N,
   input  logic                START,
   input  logic                fresh,
   input  logic                collide,
   output logic                game_status,
   output logic [3:0]          speed,
   output logic [NSLOT-1:0]    slot_active,
   output logic [10*NSLOT-1:0] slot_pos,
   output logic [15:0]         score
);
   import dino_pkg::*;

   game_state_t state_q, state_d;

   logic             fresh_d;
   logic             tick;
   logic [15:0]      lfsr;
   logic [15:0]      gap_cnt;
   logic [15:0]      ramp_cnt;
   logic             run_clear;
   logic             adv;
   logic             spawn_en;
   logic [NSLOT-1:0] retire_next;
   logic [NSLOT-1:0] free_v;
   logic [NSLOT-1:0] spawn_sel;
   logic             found;

   assign tick        = fresh_d & ~fresh;
   assign game_status = (state_q == RUN);
   assign run_clear   = (state_q != RUN) && START;
   // collide wins over a same-cycle tick, so the frame is dropped
   assign adv         = (state_q == RUN) && tick && !collide;
   assign spawn_en    = adv && (gap_cnt == 16'd0);
   assign free_v      = ~slot_active | retire_next;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (START)   state_d = RUN;
         RUN:     if (collide) state_d = OVER;
         OVER:    if (START)   state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      spawn_sel = '0;
      found     = 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
         if (spawn_en && free_v[i] && !found) begin
            spawn_sel[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         fresh_d  <= 1'b1;
         lfsr     <= LFSR_SEED;
         speed    <= 4'(SPEED_INIT);
         score    <= '0;
         gap_cnt  <= '0;
         ramp_cnt <= '0;
      end else begin
         state_q <= state_d;
         fresh_d <= fresh;
         lfsr    <= lfsr_next(lfsr);
         if (run_clear) begin
            speed    <= 4'(SPEED_INIT);
            score    <= '0;
            gap_cnt  <= '0;
            ramp_cnt <= '0;
         end else if (adv) begin
            if (score != 16'hFFFF) score <= score + 16'd1;
            // with every slot busy the gap stays at zero and the spawn retries next frame
            if (gap_cnt == 16'd0) begin
               if (found) gap_cnt <= 16'(MIN_GAP) + (lfsr & 16'(GAP_MASK));
            end else begin
               gap_cnt <= gap_cnt - 16'd1;
            end
            if (ramp_cnt == 16'(RAMP_FRAMES - 1)) begin
               ramp_cnt <= '0;
               if (speed < 4'(SPEED_MAX)) speed <= speed + 4'd1;
            end else begin
               ramp_cnt <= ramp_cnt + 16'd1;
            end
         end
      end
   end

   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      obstacle_slot #(
         .EXIT_POS (EXIT_POS)
      ) u_slot (
         .clk         (clk),
         .rst_n       (RESET_N),
         .tick_adv    (adv),
         .spawn       (spawn_sel[i]),
         .clear       (run_clear),
         .speed       (speed),
         .pos         (slot_pos[10*i +: 10]),
         .active      (slot_active[i]),
         .retire_next (retire_next[i])
      );
   end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: three configurations driven in lockstep against a frame-level model.
module tb_obstacle_scheduler;

   logic clk = 1'b0;
   logic RESET_N = 1'b0;
   logic START = 1'b0;
   logic fresh = 1'b1;
   logic collide = 1'b0;

   logic [2:0]        gs;
   logic [2:0][3:0]   spd;
   logic [2:0][2:0]   act;
   logic [2:0][29:0]  pos;
   logic [2:0][15:0]  sc;

   int n_chk = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   // A: fixed gap 40, B: fixed gap 1, C: LFSR-randomised gap
   obstacle_scheduler #(.MIN_GAP(40), .GAP_MASK(0)) u_a (
      .clk(clk), .RESET_N(RESET_N), .START(START), .fresh(fresh), .collide(collide),
      .game_status(gs[0]), .speed(spd[0]), .slot_active(act[0]), .slot_pos(pos[0]), .score(sc[0]));
   obstacle_scheduler #(.MIN_GAP(1), .GAP_MASK(0)) u_b (
      .clk(clk), .RESET_N(RESET_N), .START(START), .fresh(fresh), .collide(collide),
      .game_status(gs[1]), .speed(spd[1]), .slot_active(act[1]), .slot_pos(pos[1]), .score(sc[1]));
   obstacle_scheduler u_c (
      .clk(clk), .RESET_N(RESET_N), .START(START), .fresh(fresh), .collide(collide),
      .game_status(gs[2]), .speed(spd[2]), .slot_active(act[2]), .slot_pos(pos[2]), .score(sc[2]));

   task automatic chk(input string nm, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame-level game rules) ----------------
   int       m_st[3];          // 0 idle, 1 running, 2 game over
   int       m_spd[3], m_score[3], m_gap[3], m_ramp[3];
   int       m_pos[3][3];
   bit       m_act[3][3];
   bit [15:0] m_lfsr[3];
   bit       m_fd[3];

   function automatic int min_gap(input int k);
      return (k == 1) ? 1 : 40;
   endfunction
   function automatic int gmask(input int k);
      return (k == 2) ? 63 : 0;
   endfunction

   task automatic model_reset(input int k);
      m_st[k] = 0; m_spd[k] = 4; m_score[k] = 0; m_gap[k] = 0; m_ramp[k] = 0;
      m_lfsr[k] = 16'hACE1; m_fd[k] = 1'b1;
      for (int s = 0; s < 3; s++) begin m_pos[k][s] = 0; m_act[k][s] = 1'b0; end
   endtask

   task automatic model_step(input int k);
      bit tk;
      bit [15:0] l;
      int fs;
      tk = m_fd[k] && !fresh;
      l = m_lfsr[k];
      m_fd[k] = fresh;
      m_lfsr[k] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      if (m_st[k] != 1) begin
         if (START) begin
            m_st[k] = 1; m_spd[k] = 4; m_score[k] = 0; m_gap[k] = 0; m_ramp[k] = 0;
            for (int s = 0; s < 3; s++) begin m_pos[k][s] = 0; m_act[k][s] = 1'b0; end
         end
      end else if (collide) begin
         m_st[k] = 2;
      end else if (tk) begin
         for (int s = 0; s < 3; s++)
            if (m_act[k][s]) begin
               if (m_pos[k][s] + m_spd[k] >= 700) begin m_act[k][s] = 1'b0; m_pos[k][s] = 0; end
               else m_pos[k][s] = m_pos[k][s] + m_spd[k];
            end
         fs = -1;
         for (int s = 2; s >= 0; s--) if (!m_act[k][s]) fs = s;
         if (m_gap[k] == 0) begin
            if (fs >= 0) begin
               m_act[k][fs] = 1'b1; m_pos[k][fs] = 0;
               m_gap[k] = min_gap(k) + (int'(l) & gmask(k));
            end
         end else m_gap[k] = m_gap[k] - 1;
         if (m_score[k] < 65535) m_score[k] = m_score[k] + 1;
         if (m_ramp[k] == 599) begin
            m_ramp[k] = 0;
            if (m_spd[k] < 12) m_spd[k] = m_spd[k] + 1;
         end else m_ramp[k] = m_ramp[k] + 1;
      end
   endtask

   always @(posedge clk or negedge RESET_N) begin
      for (int k = 0; k < 3; k++)
         if (!RESET_N) model_reset(k);
         else model_step(k);
   end

   always @(negedge clk) begin
      if (cmp_en)
         for (int k = 0; k < 3; k++) begin
            logic [29:0] ep;
            logic [2:0]  ea;
            for (int s = 0; s < 3; s++) begin
               ep[10*s +: 10] = 10'(m_pos[k][s]);
               ea[s] = m_act[k][s];
            end
            chk($sformatf("model_cfg%0d", k),
                longint'({gs[k], spd[k], act[k], pos[k], sc[k]}),
                longint'({(m_st[k] == 1), 4'(m_spd[k]), ea, ep, 16'(m_score[k])}));
         end
   end

   // ---------------- stimulus ----------------
   task automatic frame(input bit col);
      fresh = 1'b1;
      @(negedge clk);
      fresh = 1'b0;
      collide = col;
      @(negedge clk);
      collide = 1'b0;
   endtask

   task automatic start_pulse();
      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
   endtask

   typedef struct {
      bit start; bit col; int n;
      int gs; int spd; int act; int p0; int p1; int score;
   } rec_t;

   rec_t tbl[17];

   initial begin
      tbl[0]  = '{1, 0, 1,    1, 4,  1,  0,   0,   1};
      tbl[1]  = '{0, 0, 41,   1, 4,  3,  164, 0,   42};
      tbl[2]  = '{0, 0, 8,    1, 4,  3,  196, 32,  50};
      tbl[3]  = '{0, 1, 1,    0, 4,  3,  196, 32,  50};
      tbl[4]  = '{0, 0, 5,    0, 4,  3,  196, 32,  50};
      tbl[5]  = '{0, 1, 3,    0, 4,  3,  196, 32,  50};
      tbl[6]  = '{1, 0, 0,    1, 4,  0,  0,   0,   0};
      tbl[7]  = '{0, 0, 1,    1, 4,  1,  0,   0,   1};
      tbl[8]  = '{0, 0, 41,   1, 4,  3,  164, 0,   42};
      tbl[9]  = '{0, 0, 133,  1, 4,  7,  696, 532, 175};
      tbl[10] = '{0, 0, 1,    1, 4,  7,  0,   536, 176};
      tbl[11] = '{0, 0, 423,  1, 4,  -1, -1,  -1,  599};
      tbl[12] = '{0, 0, 1,    1, 5,  -1, -1,  -1,  600};
      tbl[13] = '{0, 0, 4199, 1, 11, -1, -1,  -1,  4799};
      tbl[14] = '{0, 0, 1,    1, 12, -1, -1,  -1,  4800};
      tbl[15] = '{0, 0, 600,  1, 12, -1, -1,  -1,  5400};
      tbl[16] = '{1, 0, 1,    1, 12, -1, -1,  -1,  5401};

      repeat (3) @(negedge clk);
      RESET_N = 1'b1;
      @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_status", gs[0], 0);
      chk("reset_speed", spd[0], 4);
      chk("reset_active", act[0], 0);
      chk("reset_score", sc[0], 0);

      for (int i = 0; i < 17; i++) begin
         if (tbl[i].start) start_pulse();
         repeat (tbl[i].n) frame(tbl[i].col);
         chk($sformatf("rec%0d_status", i), gs[0], tbl[i].gs);
         chk($sformatf("rec%0d_speed", i), spd[0], tbl[i].spd);
         chk($sformatf("rec%0d_score", i), sc[0], tbl[i].score);
         if (tbl[i].act >= 0) chk($sformatf("rec%0d_active", i), act[0], tbl[i].act);
         if (tbl[i].p0 >= 0) chk($sformatf("rec%0d_pos0", i), pos[0][9:0], tbl[i].p0);
         if (tbl[i].p1 >= 0) chk($sformatf("rec%0d_pos1", i), pos[0][19:10], tbl[i].p1);
      end

      // asynchronous reset between clock edges, START held during reset
      @(posedge clk);
      #2;
      RESET_N = 1'b0;
      START = 1'b1;
      #1;
      chk("async_rst_status", gs[0], 0);
      chk("async_rst_speed", spd[0], 4);
      chk("async_rst_active", act[0], 0);
      chk("async_rst_pos", pos[0], 0);
      chk("async_rst_score", sc[0], 0);
      repeat (3) @(negedge clk);
      START = 1'b0;
      RESET_N = 1'b1;
      @(negedge clk);
      chk("start_during_rst_ignored", gs[0], 0);

      // gap of one: pool fills, next spawn waits for slot 0 to retire
      start_pulse();
      frame(0);
      chk("gap1_t1_active", act[1], 3'b001);
      repeat (2) frame(0);
      chk("gap1_t3_active", act[1], 3'b011);
      repeat (2) frame(0);
      chk("gap1_t5_active", act[1], 3'b111);
      chk("gap1_t5_pos0", pos[1][9:0], 16);
      repeat (170) frame(0);
      chk("gap1_t175_active", act[1], 3'b111);
      chk("gap1_t175_pos0", pos[1][9:0], 696);
      frame(0);
      chk("gap1_t176_active", act[1], 3'b111);
      chk("gap1_t176_pos0", pos[1][9:0], 0);
      chk("gap1_t176_pos1", pos[1][19:10], 692);

      // random frames, collisions and restarts
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         fresh = 1'($urandom_range(0, 1));
         collide = ($urandom_range(0, 199) == 0);
         START = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      START = 1'b0;
      collide = 1'b0;
      @(negedge clk);
      cmp_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
